// File: rtl/wb_spram_bridge.sv
// -----------------------------------------------------------------------------
// wb_spram_bridge
//
// Pipelined Wishbone B4 slave in front of a single-port 32-bit synchronous RAM
// (one-cycle read latency, per-byte write enables). Bus requests are turned
// directly into RAM ce/we/addr/d strobes in the same cycle. The ack/err
// response is registered, so it always arrives exactly one cycle after
// acceptance. One request per cycle is sustained with no bubbles.
//
// After reset the bridge can optionally zero-fill the whole RAM (CLEAR state)
// before it starts serving the bus (RUN state).
//
// Ports
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   wb_cyc, wb_stb    bus cycle valid / request strobe
//   wb_we, wb_sel     write enable and byte selects (selects apply to writes)
//   wb_adr            byte address; bits [1:0] are ignored
//   wb_dat_i          write data
//   wb_dat_o          read data, valid together with wb_ack, otherwise zero
//   wb_ack, wb_err    normal / error (out-of-range) termination
//   wb_stall          high while the bridge cannot accept a request
//   ram_addr          RAM word address
//   ram_ce, ram_we    RAM chip enable and byte write enables
//   ram_d, ram_q      RAM write data / read data (q valid one cycle after ce)
//   init_done         high once the RAM is usable
// -----------------------------------------------------------------------------
module wb_spram_bridge #(
    parameter int size           = 'h80,
    parameter int addr_width     = $clog2(size) - 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic [31:0]           wb_adr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  wb_stall,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_ce,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_d,
    input  logic [31:0]           ram_q,
    output logic                  init_done
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    // size is a power of two, so the last word index is all ones.
    localparam logic [addr_width-1:0] CNT_LAST = {addr_width{1'b1}};

    state_t                state_q, state_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  rd_q, rd_d;

    logic                  accept;
    logic                  in_range;
    logic [addr_width-1:0] word_idx;

    // The compare spans the full address, so any high bit set is out of range.
    assign in_range = (wb_adr < 32'(size));
    assign word_idx = wb_adr[addr_width+1:2];

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rd_d      = 1'b0;
        accept    = 1'b0;
        wb_stall  = 1'b1;
        init_done = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = word_idx;
        ram_d     = wb_dat_i;

        case (state_q)
            CLEAR: begin
                ram_ce   = 1'b1;
                ram_we   = 4'hf;
                ram_d    = 32'h0;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                wb_stall  = 1'b0;
                accept    = wb_cyc & wb_stb;
                if (accept) begin
                    if (in_range) begin
                        ram_ce = 1'b1;
                        ram_we = wb_we ? wb_sel : 4'h0;
                        ack_d  = 1'b1;
                        rd_d   = ~wb_we;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
        endcase

        // The state register already holds its reset value during rst, but the
        // strobes are combinational, so block RAM access explicitly as well.
        if (rst) begin
            ram_ce = 1'b0;
            ram_we = 4'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // A response is visible only while the master still holds cyc; if cyc
    // drops in the response cycle the response is lost rather than delayed.
    assign wb_ack   = ack_q & wb_cyc;
    assign wb_err   = err_q & wb_cyc;
    assign wb_dat_o = (ack_q & rd_q) ? ram_q : 32'h0;

endmodule

// File: tb/tb_wb_spram_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_spram_bridge
//
// Directed bench for wb_spram_bridge (size='h80). A behavioural single-port
// RAM with byte enables and one-cycle read latency sits on the RAM port. A
// second instance with CLEAR_ON_RESET=0 checks immediate availability.
// Inputs are driven 1ns after the rising edge and outputs sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_wb_spram_bridge;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_adr;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack;
    logic          wb_err;
    logic          wb_stall;
    logic [AW-1:0] ram_addr;
    logic          ram_ce;
    logic [3:0]    ram_we;
    logic [31:0]   ram_d;
    logic [31:0]   ram_q;
    logic          init_done;

    // Second instance, no clear; bus idle.
    logic          n_cyc, n_stb, n_we;
    logic [3:0]    n_sel;
    logic [31:0]   n_adr, n_dat_i, n_ram_q;
    logic [31:0]   n_dat_o, n_ram_d;
    logic          n_ack, n_err, n_stall, n_ram_ce, n_init_done;
    logic [AW-1:0] n_ram_addr;
    logic [3:0]    n_ram_we;

    int checks;
    int failures;

    // RAM model
    logic [31:0] mem [32];
    logic        fill_req;
    logic [31:0] fill_val;

    wb_spram_bridge #(.size('h80), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
        .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_d(ram_d), .ram_q(ram_q), .init_done(init_done)
    );

    wb_spram_bridge #(.size('h80), .CLEAR_ON_RESET(1'b0)) u_dut_noclr (
        .clk(clk), .rst(rst),
        .wb_cyc(n_cyc), .wb_stb(n_stb), .wb_we(n_we), .wb_sel(n_sel),
        .wb_adr(n_adr), .wb_dat_i(n_dat_i), .wb_dat_o(n_dat_o),
        .wb_ack(n_ack), .wb_err(n_err), .wb_stall(n_stall),
        .ram_addr(n_ram_addr), .ram_ce(n_ram_ce), .ram_we(n_ram_we),
        .ram_d(n_ram_d), .ram_q(n_ram_q), .init_done(n_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= fill_val;
        end else if (ram_ce) begin
            ram_q <= mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
        wb_cyc   = cyc;
        wb_stb   = stb;
        wb_we    = we;
        wb_sel   = sel;
        wb_adr   = adr;
        wb_dat_i = dat;
    endtask

    // T1: reset values, 32-word clear sequence, clean reads at both ends.
    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        fill_val = 32'hDEAD_BEEF;
        fill_req = 1'b1;
        tick;
        fill_req = 1'b0;
        tick;
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_resp: ack=%b err=%b dat=%h expected 0 0 00000000", wb_ack, wb_err, wb_dat_o);
        end
        checks++;
        if (ram_ce !== 1'b0 || ram_we !== 4'h0 || wb_stall !== 1'b1 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_ram: ce=%b we=%h stall=%b init=%b expected 0 0 1 0", ram_ce, ram_we, wb_stall, init_done);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (n_stall !== 1'b0 || n_init_done !== 1'b1) begin
            failures++;
            $display("FAIL noclr_first: stall=%b init=%b expected 0 1", n_stall, n_init_done);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (ram_ce !== 1'b1 || ram_we !== 4'hf || ram_d !== 32'h0 ||
                ram_addr !== AW'(i) || wb_stall !== 1'b1 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL clear_%0d: ce=%b we=%h d=%h addr=%0d stall=%b init=%b expected 1 f 0 %0d 1 0",
                         i, ram_ce, ram_we, ram_d, ram_addr, wb_stall, init_done, i);
            end
            tick;
        end
        checks++;
        if (init_done !== 1'b1 || wb_stall !== 1'b0 || ram_ce !== 1'b0) begin
            failures++;
            $display("FAIL clear_end: init=%b stall=%b ce=%b expected 1 0 0", init_done, wb_stall, ram_ce);
        end
        drive(1, 1, 0, 4'h0, 32'h00, 32'h0);
        tick;
        drive(1, 1, 0, 4'h0, 32'h7c, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL rd_00: ack=%b dat=%h expected 1 00000000", wb_ack, wb_dat_o);
        end
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL rd_7c: ack=%b err=%b dat=%h expected 1 0 00000000", wb_ack, wb_err, wb_dat_o);
        end
        tick;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // T2: full-word write followed immediately by a read of the same word.
    task automatic test_write_read;
        drive(1, 1, 1, 4'hf, 32'h10, 32'h1234_5678);
        #1;
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'hf || ram_addr !== AW'(4) || ram_d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL wr_strobe: ce=%b we=%h addr=%0d d=%h expected 1 f 4 12345678", ram_ce, ram_we, ram_addr, ram_d);
        end
        tick;
        drive(1, 1, 0, 4'h0, 32'h10, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL wr_ack: ack=%b err=%b dat=%h expected 1 0 00000000", wb_ack, wb_err, wb_dat_o);
        end
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'h0) begin
            failures++;
            $display("FAIL rd_strobe: ce=%b we=%h expected 1 0", ram_ce, ram_we);
        end
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_after_wr: ack=%b dat=%h expected 1 12345678", wb_ack, wb_dat_o);
        end
        tick;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // T3: partial byte write, then a sel=0 write that must not change the word.
    task automatic test_byte_sel;
        drive(1, 1, 1, 4'b0101, 32'h10, 32'hAABB_CCDD);
        tick;
        drive(1, 1, 0, 4'h0, 32'h10, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1) begin
            failures++;
            $display("FAIL sel5_ack: ack=%b expected 1", wb_ack);
        end
        tick;
        drive(1, 1, 1, 4'h0, 32'h10, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h12BB_56DD) begin
            failures++;
            $display("FAIL sel5_rd: ack=%b dat=%h expected 1 12bb56dd", wb_ack, wb_dat_o);
        end
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'h0) begin
            failures++;
            $display("FAIL sel0_strobe: ce=%b we=%h expected 1 0", ram_ce, ram_we);
        end
        tick;
        drive(1, 1, 0, 4'hf, 32'h10, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h0 || ram_we !== 4'h0) begin
            failures++;
            $display("FAIL sel0_ack: ack=%b dat=%h rd_we=%h expected 1 00000000 0", wb_ack, wb_dat_o, ram_we);
        end
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h12BB_56DD) begin
            failures++;
            $display("FAIL sel0_rd: ack=%b dat=%h expected 1 12bb56dd", wb_ack, wb_dat_o);
        end
        tick;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // T4: out-of-range read and write produce err and never touch the RAM.
    task automatic test_out_of_range;
        drive(1, 1, 0, 4'h0, 32'h80, 32'h0);
        #1;
        checks++;
        if (ram_ce !== 1'b0 || ram_we !== 4'h0) begin
            failures++;
            $display("FAIL oor_rd_strobe: ce=%b we=%h expected 0 0", ram_ce, ram_we);
        end
        tick;
        drive(1, 1, 1, 4'hf, 32'hFFFF_FFFC, 32'h0000_1111);
        #1;
        checks++;
        if (ram_ce !== 1'b0 || ram_we !== 4'h0) begin
            failures++;
            $display("FAIL oor_wr_strobe: ce=%b we=%h expected 0 0", ram_ce, ram_we);
        end
        checks++;
        if (wb_err !== 1'b1 || wb_ack !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL oor_rd_err: err=%b ack=%b dat=%h expected 1 0 00000000", wb_err, wb_ack, wb_dat_o);
        end
        tick;
        drive(1, 1, 0, 4'h0, 32'h7c, 32'h0);
        #1;
        checks++;
        if (wb_err !== 1'b1 || wb_ack !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL oor_wr_err: err=%b ack=%b dat=%h expected 1 0 00000000", wb_err, wb_ack, wb_dat_o);
        end
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL oor_word31: ack=%b err=%b dat=%h expected 1 0 00000000", wb_ack, wb_err, wb_dat_o);
        end
        tick;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // T5: back-to-back read/write; cyc dropped for the write's response cycle.
    task automatic test_back_to_back;
        drive(1, 1, 0, 4'h0, 32'h00, 32'h0);
        tick;
        drive(1, 1, 1, 4'hf, 32'h04, 32'hCAFE_F00D);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL b2b_ack1: ack=%b err=%b dat=%h expected 1 0 00000000", wb_ack, wb_err, wb_dat_o);
        end
        tick;
        // stb without cyc: response of the write dropped, no new request
        drive(0, 1, 1, 4'hf, 32'h04, 32'h0000_0BAD);
        #1;
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0 || ram_ce !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ack0: ack=%b err=%b ce=%b expected 0 0 0", wb_ack, wb_err, ram_ce);
        end
        tick;
        drive(1, 1, 0, 4'h0, 32'h04, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_delay: ack=%b expected 0", wb_ack);
        end
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL b2b_ack2: ack=%b dat=%h expected 1 cafef00d", wb_ack, wb_dat_o);
        end
        tick;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // T6: reset in RUN drops a pending ack; reset mid-CLEAR restarts the fill.
    task automatic test_reset_mid_clear;
        drive(1, 1, 1, 4'hf, 32'h08, 32'h5555_AAAA);
        tick;
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (wb_ack !== 1'b0 || ram_ce !== 1'b0 || wb_stall !== 1'b1 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_run: ack=%b ce=%b stall=%b init=%b expected 0 0 1 0", wb_ack, ram_ce, wb_stall, init_done);
        end
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        fill_val = 32'hA5A5_A5A5;
        fill_req = 1'b1;
        tick;
        fill_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        checks++;
        if (ram_addr !== AW'(10) || ram_we !== 4'hf) begin
            failures++;
            $display("FAIL mid_cnt10: addr=%0d we=%h expected 10 f", ram_addr, ram_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_ce !== 1'b0 || ram_we !== 4'h0 || wb_stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst: ce=%b we=%h stall=%b expected 0 0 1", ram_ce, ram_we, wb_stall);
        end
        fill_req = 1'b1;
        tick;
        fill_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (ram_addr !== AW'(0) || ram_ce !== 1'b1 || ram_we !== 4'hf) begin
            failures++;
            $display("FAIL mid_restart: addr=%0d ce=%b we=%h expected 0 1 f", ram_addr, ram_ce, ram_we);
        end
        checks++;
        if (n_stall !== 1'b0 || n_init_done !== 1'b1) begin
            failures++;
            $display("FAIL noclr_after_rst: stall=%b init=%b expected 0 1", n_stall, n_init_done);
        end
        for (int i = 0; i < 32; i++) tick;
        checks++;
        if (init_done !== 1'b1 || wb_stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_done: init=%b stall=%b expected 1 0", init_done, wb_stall);
        end
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) drive(1, 1, 0, 4'h0, 32'(i * 4), 32'h0);
            else        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
            #1;
            if (i > 0) begin
                checks++;
                if (wb_ack !== 1'b1 || wb_dat_o !== 32'h0) begin
                    failures++;
                    $display("FAIL zero_word_%0d: ack=%b dat=%h expected 1 00000000", i - 1, wb_ack, wb_dat_o);
                end
            end
            tick;
        end
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        fill_req = 1'b0;
        fill_val = 32'h0;
        n_cyc    = 1'b0;
        n_stb    = 1'b0;
        n_we     = 1'b0;
        n_sel    = 4'h0;
        n_adr    = 32'h0;
        n_dat_i  = 32'h0;
        n_ram_q  = 32'h0;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);

        test_reset;
        test_write_read;
        test_byte_sel;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid_clear;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
